root_port_arbiter: RTL

ROOT_PORT_ARBITER -- requirements
Module: root_port_arbiter

---
 rtl/root_port_arbiter_pkg.sv | 17 +
 rtl/root_port_arbiter_rr_select.sv | 36 +++
 rtl/root_port_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/root_port_arbiter_pkg.sv
// Shared definitions for the root port arbiter: output-register state
// encoding, stall counter width and an index-width helper.
package root_port_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  localparam int STALL_CNT_WIDTH = 16;

  // Width needed to hold a channel index; at least one bit for single-channel builds.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/root_port_arbiter_rr_select.sv
// Round-robin priority search: picks the first requesting channel above
// ptr, wrapping at N-1 back to 0, with ptr itself considered last.
// Only indices below N can ever be selected.
module rr_select
  import root_port_arbiter_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Rotating scan over offsets 1..N from the pointer; first hit wins.
  always_comb begin
    int cand;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        index       = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/root_port_arbiter.sv
// Root port arbiter: selects one of NUM_CHANNELS input channels whose
// destination field matches PORT_ID, round-robin, into a single registered
// output word with valid/ready handshake.
// Optional stall counter enabled by defining ROOT_ARB_STALL_COUNTER_EN.
module root_port_arbiter
  import root_port_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS  = 5,
  parameter int CHANNEL_WIDTH = 64,
  parameter int DEST_WIDTH    = 8,
  parameter int PORT_ID       = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] rx_data,
  input  logic [NUM_CHANNELS-1:0]             rx_valid,
  output logic [NUM_CHANNELS-1:0]             rx_ready,
  output logic [CHANNEL_WIDTH-1:0]            tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic [STALL_CNT_WIDTH-1:0]          stall_cycles
);

  localparam int                    IDX_W     = idx_width(NUM_CHANNELS);
  localparam logic [IDX_W-1:0]      PTR_RESET = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [DEST_WIDTH-1:0] PORT_DEST = DEST_WIDTH'(PORT_ID);

  arb_state_e               state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;

  logic [CHANNEL_WIDTH-1:0] ch_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  req;
  logic [NUM_CHANNELS-1:0]  win_onehot;
  logic [IDX_W-1:0]         win_idx;
  logic                     win_any;
  logic                     load_ok;
  logic                     grant;

  // Unpack channels and flag those addressed to this port.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    assign ch_data[i] = rx_data[CHANNEL_WIDTH*i +: CHANNEL_WIDTH];
    assign req[i]     = rx_valid[i] &&
                        (ch_data[i][CHANNEL_WIDTH-1 -: DEST_WIDTH] == PORT_DEST);
  end

  rr_select #(
    .N     (NUM_CHANNELS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req   (req),
    .ptr   (ptr_q),
    .grant (win_onehot),
    .index (win_idx),
    .any   (win_any)
  );

  // The output register can take a new word when empty or being drained this cycle.
  assign load_ok  = (state_q == EMPTY) || tx_ready;
  assign grant    = load_ok && win_any;
  // Gating with reset keeps the pop strobes quiet while reset is held.
  assign rx_ready = (reset && grant) ? win_onehot : '0;
  assign tx_valid = (state_q == FULL);
  assign tx_data  = tx_data_q;

  // Next-state: load on grant, otherwise drain when the consumer accepts.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    ptr_d     = ptr_q;
    if (grant) begin
      state_d   = FULL;
      tx_data_d = ch_data[win_idx];
      ptr_d     = win_idx;
    end else if (tx_ready) begin
      state_d = EMPTY;
    end
  end

  // State, output word and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      tx_data_q <= '0;
      ptr_q     <= PTR_RESET;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of its peers.
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef ROOT_ARB_STALL_COUNTER_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  // Count cycles where a word is offered but not taken, sticking at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (tx_valid && !tx_ready && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
